cpu_axi_master: RTL and testbench
=================================

# cpu_axi_master

Converts a CPU memory port (instruction or data) into single-beat AXI4 master transactions on one master port of the AXI bus that feeds the SRAM slave wrappers. Each CPU access is latched and issued as one AR/R or AW/W/B transaction. The CPU is held with `stall_o` until the response handshake completes. Two instances are used per core, one for IM and one for DM.

## Interface
Parameters:
- `MASTER_ID`, default 4'd0: value driven on ARID/AWID (`AXI_ID_BITS` wide).

Ports:
- `ACLK` in 1: clock.
- `ARESETn` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: CPU access request. Held stable with its attributes while `stall_o`=1.
- `req_write_i` in 1: 1 = store, 0 = load.
- `req_addr_i` in 32: byte address, word aligned.
- `req_wdata_i` in 32: store data.
- `req_wstrb_i` in 4: byte enables, active-high.
- `stall_o` out 1: CPU must hold.
- `rdata_o` out 32: load data. Valid only in the completion cycle.
- `err_o` out 1: sticky response error (see Configuration).
- AXI master channels, `AXI_define.svh` widths:
  - AR: `ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID` out, `ARREADY` in.
  - R: `RID/RDATA/RRESP/RLAST/RVALID` in, `RREADY` out.
  - AW: `AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID` out, `AWREADY` in.
  - W: `WDATA/WSTRB/WLAST/WVALID` out, `WREADY` in.
  - B: `BID/BRESP/BVALID` in, `BREADY` out.

## Operation
- Constant outputs: `ARLEN=AWLEN=0`, `ARSIZE=AWSIZE=3'b010`, `ARBURST=AWBURST=2'b01` (INCR), `WLAST=1`, `ARID=AWID=MASTER_ID`.
- The request register (write, addr, wdata, wstrb) is captured in IDLE when `req_valid_i`=1. All AXI address/data outputs come from this register, never from the CPU inputs directly.
- FSM states and transitions:
  - IDLE: if `req_valid_i`, go to RD_ADDR (load) or WR_REQ (store). Otherwise stay.
  - RD_ADDR: `ARVALID`=1. On ARREADY, go to RD_DATA.
  - RD_DATA: `RREADY`=1. On RVALID, this is the completion cycle: `rdata_o`=RDATA, go to IDLE.
  - WR_REQ: `AWVALID`=1 until the AW handshake, `WVALID`=1 until the W handshake. Two flags `aw_done`/`w_done` record each handshake. When both are done (including both in the same cycle), go to WR_RESP.
  - WR_RESP: `BREADY`=1. On BVALID, this is the completion cycle; go to IDLE.
- `stall_o` = (`req_valid_i` in IDLE) OR (state≠IDLE AND not completion cycle). It is 0 in the completion cycle, so the CPU advances and may present its next request in the next cycle.
- VALID handshakes: once asserted, ARVALID/AWVALID/WVALID are held with stable payload until READY. They are never withdrawn except by reset.
- RID/BID are not checked. RLAST is ignored because there is a single beat.
- Reset value of every output is 0, except the constant fields above. FSM goes to IDLE; flags and request register are cleared.

## Timing
- Against a slave that accepts in IDLE with one-cycle read data:
  - Load: cycle 0 latch (stall=1); cycle 1 AR handshake (stall=1); cycle 2 R handshake (stall=0, `rdata_o` valid). Minimum latency is 2 cycles after the request.
  - Store: cycle 1 AW+W handshake; cycle 2 B handshake (stall=0).
- Back-to-back requests: the earliest next ARVALID/AWVALID is 2 cycles after the completion cycle (IDLE latch, then issue).
- Reset mid-transaction: all VALID/READY outputs drop asynchronously. The outstanding CPU access is lost; the CPU is reset together with this block.
- `req_valid_i` dropping while the block is busy is ignored; the transaction completes.

## Configuration
- `CPU_AXI_MASTER_ERR_EN` defined: `err_o` is set in any completion cycle where RRESP or BRESP ≠ OKAY. It stays set until reset. The completion still occurs normally.
- Not defined: `err_o` is tied to 0 and RRESP/BRESP are ignored.

## Structure
- Package `cpu_axi_master_pkg`:
  - state enum (IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP);
  - request struct {write, addr, wdata, wstrb};
  - constants for SIZE_WORD = 3'b010 and BURST_INCR = 2'b01.
- The AXI widths and response codes come from `AXI_define.svh`.
- No sub-module. Single FSM plus request register in one file.

## Test plan
- Load, zero-wait slave: addr 0x0000_0010 with RDATA 0xDEAD_BEEF. Expect `stall_o`=1 for 2 cycles, then `rdata_o`=0xDEAD_BEEF with stall=0. ARADDR=0x10, ARLEN=0, ARSIZE=2.
- Store, AW and W ready in the same cycle: addr 0x20, data 0x1234_5678, wstrb 4'b0011. Expect WSTRB=0011 and WLAST=1. Completion occurs on the B handshake in cycle 2.
- Store with WREADY delayed 3 cycles after AWREADY: AWVALID drops after its handshake, WVALID is held stable, BREADY is asserted only after the W handshake, and stall lasts until BVALID.
- Back-to-back load then store: ARVALID and AWVALID never overlap, and the second latch occurs in the cycle after completion.
- ARESETn asserted while in RD_DATA: all VALID/READY outputs go to 0 immediately and FSM is in IDLE. After release, a new load completes normally.
- With `CPU_AXI_MASTER_ERR_EN`: a BRESP=2'b10 response sets `err_o`=1, and it stays 1 across a following OKAY load. Without the macro, `err_o`=0.

Source files
------------

// File: rtl/cpu_axi_master_pkg.sv
// Shared types and AXI constants for the CPU-port to single-beat AXI4 master bridge.
// Bus widths and response codes match the values in AXI_define.svh.
package cpu_axi_master_pkg;

    localparam int unsigned AXI_ID_BITS    = 4;
    localparam int unsigned AXI_ADDR_BITS  = 32;
    localparam int unsigned AXI_DATA_BITS  = 32;
    localparam int unsigned AXI_STRB_BITS  = 4;
    localparam int unsigned AXI_LEN_BITS   = 8;
    localparam int unsigned AXI_SIZE_BITS  = 3;
    localparam int unsigned AXI_BURST_BITS = 2;
    localparam int unsigned AXI_RESP_BITS  = 2;

    localparam logic [AXI_RESP_BITS-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_BITS-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [AXI_RESP_BITS-1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_BITS-1:0] RESP_DECERR = 2'b11;

    localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp
    } state_e;

    typedef struct packed {
        logic                     write;
        logic [AXI_ADDR_BITS-1:0] addr;
        logic [AXI_DATA_BITS-1:0] wdata;
        logic [AXI_STRB_BITS-1:0] wstrb;
    } req_t;

endpackage

// File: rtl/cpu_axi_master_if.sv
// AXI4 master port bundle (AR/R/AW/W/B) with master and slave views.
interface cpu_axi_master_if;
    import cpu_axi_master_pkg::*;

    logic [AXI_ID_BITS-1:0]    ARID;
    logic [AXI_ADDR_BITS-1:0]  ARADDR;
    logic [AXI_LEN_BITS-1:0]   ARLEN;
    logic [AXI_SIZE_BITS-1:0]  ARSIZE;
    logic [AXI_BURST_BITS-1:0] ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;

    logic [AXI_ID_BITS-1:0]    RID;
    logic [AXI_DATA_BITS-1:0]  RDATA;
    logic [AXI_RESP_BITS-1:0]  RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;

    logic [AXI_ID_BITS-1:0]    AWID;
    logic [AXI_ADDR_BITS-1:0]  AWADDR;
    logic [AXI_LEN_BITS-1:0]   AWLEN;
    logic [AXI_SIZE_BITS-1:0]  AWSIZE;
    logic [AXI_BURST_BITS-1:0] AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;

    logic [AXI_DATA_BITS-1:0]  WDATA;
    logic [AXI_STRB_BITS-1:0]  WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;

    logic [AXI_ID_BITS-1:0]    BID;
    logic [AXI_RESP_BITS-1:0]  BRESP;
    logic                      BVALID;
    logic                      BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/cpu_axi_master.sv
// Latches one CPU access and issues it as a single-beat AXI4 read or write, stalling the CPU
// until the response handshake. Define CPU_AXI_MASTER_ERR_EN to enable the sticky err_o flag.
module cpu_axi_master
    import cpu_axi_master_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     req_valid_i,
    input  logic                     req_write_i,
    input  logic [AXI_ADDR_BITS-1:0] req_addr_i,
    input  logic [AXI_DATA_BITS-1:0] req_wdata_i,
    input  logic [AXI_STRB_BITS-1:0] req_wstrb_i,
    output logic                     stall_o,
    output logic [AXI_DATA_BITS-1:0] rdata_o,
    output logic                     err_o,
    cpu_axi_master_if.master         axi
);

    state_e state_q, state_d;
    req_t   req_q, req_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   complete;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= StIdle;
            req_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        complete    = 1'b0;
        rdata_o     = '0;
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b0;
        axi.AWVALID = 1'b0;
        axi.WVALID  = 1'b0;
        axi.BREADY  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    req_d   = '{write: req_write_i, addr: req_addr_i,
                                wdata: req_wdata_i, wstrb: req_wstrb_i};
                    state_d = req_write_i ? StWrReq : StRdAddr;
                end
            end
            StRdAddr: begin
                axi.ARVALID = 1'b1;
                if (axi.ARREADY) state_d = StRdData;
            end
            StRdData: begin
                axi.RREADY = 1'b1;
                if (axi.RVALID) begin
                    complete = 1'b1;
                    rdata_o  = axi.RDATA;
                    state_d  = StIdle;
                end
            end
            StWrReq: begin
                // AW and W complete independently; leave once both have handshaken.
                axi.AWVALID = !aw_done_q;
                axi.WVALID  = !w_done_q;
                aw_done_d   = aw_done_q | axi.AWREADY;
                w_done_d    = w_done_q | axi.WREADY;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWrResp;
                end
            end
            StWrResp: begin
                axi.BREADY = 1'b1;
                if (axi.BVALID) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign stall_o = (state_q == StIdle) ? req_valid_i : !complete;

    assign axi.ARID    = MASTER_ID;
    assign axi.ARADDR  = req_q.addr;
    assign axi.ARLEN   = '0;
    assign axi.ARSIZE  = SIZE_WORD;
    assign axi.ARBURST = BURST_INCR;
    assign axi.AWID    = MASTER_ID;
    assign axi.AWADDR  = req_q.addr;
    assign axi.AWLEN   = '0;
    assign axi.AWSIZE  = SIZE_WORD;
    assign axi.AWBURST = BURST_INCR;
    assign axi.WDATA   = req_q.wdata;
    assign axi.WSTRB   = req_q.wstrb;
    assign axi.WLAST   = 1'b1;

`ifdef CPU_AXI_MASTER_ERR_EN
    logic err_q;
    logic resp_err;

    always_comb begin
        resp_err = 1'b0;
        if (state_q == StRdData && axi.RVALID && axi.RRESP != RESP_OKAY) resp_err = 1'b1;
        if (state_q == StWrResp && axi.BVALID && axi.BRESP != RESP_OKAY) resp_err = 1'b1;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | resp_err;
        end
    end

    assign err_o = err_q;

    logic unused_ids;
    assign unused_ids = ^{axi.RID, axi.BID, axi.RLAST, req_q.write};
`else
    assign err_o = 1'b0;

    logic unused_ids;
    assign unused_ids = ^{axi.RID, axi.BID, axi.RLAST, axi.RRESP, axi.BRESP, req_q.write};
`endif

endmodule

// File: tb/tb_cpu_axi_master.sv
// Scoreboard bench for cpu_axi_master: directed CPU accesses against a simple AXI slave model.
module tb_cpu_axi_master;
    import cpu_axi_master_pkg::*;

    localparam logic [AXI_ID_BITS-1:0] TbId = 4'd3;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        stall_o, err_o;
    logic [31:0] rdata_o;

    cpu_axi_master_if axi ();

    cpu_axi_master #(.MASTER_ID(TbId)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wstrb_i (req_wstrb),
        .stall_o     (stall_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .axi         (axi)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_wd_q[$];
    logic [3:0]  exp_ws_q[$];
    logic [31:0] exp_rd_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model
    logic        ar_rdy, aw_rdy, w_rdy, r_en;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_rresp, slv_bresp;
    logic        aw_seen, w_seen, aw_now, w_now;

    assign axi.ARREADY = ar_rdy;
    assign axi.AWREADY = aw_rdy;
    assign axi.WREADY  = w_rdy;
    assign axi.RID     = TbId;
    assign axi.BID     = TbId;
    assign aw_now = aw_seen | (axi.AWVALID & axi.AWREADY);
    assign w_now  = w_seen | (axi.WVALID & axi.WREADY);

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            axi.RVALID <= 1'b0;
            axi.RDATA  <= '0;
            axi.RRESP  <= '0;
            axi.RLAST  <= 1'b0;
            axi.BVALID <= 1'b0;
            axi.BRESP  <= '0;
            aw_seen    <= 1'b0;
            w_seen     <= 1'b0;
        end else begin
            if (axi.RVALID && axi.RREADY) axi.RVALID <= 1'b0;
            if (axi.ARVALID && axi.ARREADY && r_en) begin
                axi.RVALID <= 1'b1;
                axi.RDATA  <= slv_rdata;
                axi.RRESP  <= slv_rresp;
                axi.RLAST  <= 1'b1;
            end
            if (axi.BVALID && axi.BREADY) axi.BVALID <= 1'b0;
            if (aw_now && w_now) begin
                axi.BVALID <= 1'b1;
                axi.BRESP  <= slv_bresp;
                aw_seen    <= 1'b0;
                w_seen     <= 1'b0;
            end else begin
                aw_seen <= aw_now;
                w_seen  <= w_now;
            end
        end
    end

    // Monitor: pops expectations on every handshake
    logic        w_pend_prev = 1'b0;
    logic [31:0] wdata_prev = '0;

    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (axi.ARVALID || axi.AWVALID)
                chk("ar_aw_exclusive", {31'd0, axi.ARVALID & axi.AWVALID}, 32'd0);
            if (w_pend_prev) begin
                chk("wvalid_held", {31'd0, axi.WVALID}, 32'd1);
                chk("wdata_stable", axi.WDATA, wdata_prev);
            end
            if (axi.BREADY) chk("bready_after_w", 32'(exp_wd_q.size()), 32'd0);
            if (axi.ARVALID && axi.ARREADY) begin
                chk("ar_expected", {31'd0, exp_ar_q.size() != 0}, 32'd1);
                if (exp_ar_q.size() != 0) begin
                    chk("araddr", axi.ARADDR, exp_ar_q.pop_front());
                    chk("arlen", {24'd0, axi.ARLEN}, 32'd0);
                    chk("arsize", {29'd0, axi.ARSIZE}, 32'd2);
                    chk("arburst", {30'd0, axi.ARBURST}, 32'd1);
                    chk("arid", {28'd0, axi.ARID}, 32'd3);
                end
            end
            if (axi.AWVALID && axi.AWREADY) begin
                chk("aw_expected", {31'd0, exp_aw_q.size() != 0}, 32'd1);
                if (exp_aw_q.size() != 0) begin
                    chk("awaddr", axi.AWADDR, exp_aw_q.pop_front());
                    chk("awlen", {24'd0, axi.AWLEN}, 32'd0);
                    chk("awsize", {29'd0, axi.AWSIZE}, 32'd2);
                    chk("awburst", {30'd0, axi.AWBURST}, 32'd1);
                    chk("awid", {28'd0, axi.AWID}, 32'd3);
                end
            end
            if (axi.WVALID && axi.WREADY) begin
                chk("w_expected", {31'd0, exp_wd_q.size() != 0}, 32'd1);
                if (exp_wd_q.size() != 0) begin
                    chk("wdata", axi.WDATA, exp_wd_q.pop_front());
                    chk("wstrb", {28'd0, axi.WSTRB}, {28'd0, exp_ws_q.pop_front()});
                    chk("wlast", {31'd0, axi.WLAST}, 32'd1);
                end
            end
            if (axi.RVALID && axi.RREADY) begin
                chk("rd_expected", {31'd0, exp_rd_q.size() != 0}, 32'd1);
                if (exp_rd_q.size() != 0) chk("rdata", rdata_o, exp_rd_q.pop_front());
                chk("r_stall", {31'd0, stall_o}, 32'd0);
            end
            if (axi.BVALID && axi.BREADY) chk("b_stall", {31'd0, stall_o}, 32'd0);
            w_pend_prev = axi.WVALID && !axi.WREADY;
            wdata_prev  = axi.WDATA;
        end else begin
            w_pend_prev = 1'b0;
        end
    end

    // Issue one access just after a rising edge; returns number of stalled cycles.
    task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [31:0] exp_rdata, output int cyc);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        if (wr) begin
            exp_aw_q.push_back(addr);
            exp_wd_q.push_back(data);
            exp_ws_q.push_back(strb);
        end else begin
            exp_ar_q.push_back(addr);
            exp_rd_q.push_back(exp_rdata);
        end
        cyc = 0;
        @(negedge ACLK);
        while (stall_o && cyc < 40) begin
            @(negedge ACLK);
            cyc++;
        end
        if (stall_o) chk("op_timeout", 32'(cyc), 32'd0);
        @(posedge ACLK);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        ar_rdy = 1'b1;
        aw_rdy = 1'b1;
        w_rdy  = 1'b1;
        r_en   = 1'b1;
        slv_rdata = '0;
        slv_rresp = 2'b00;
        slv_bresp = 2'b00;

        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_arvalid", {31'd0, axi.ARVALID}, 32'd0);
        chk("rst_awvalid", {31'd0, axi.AWVALID}, 32'd0);
        chk("rst_wvalid", {31'd0, axi.WVALID}, 32'd0);
        chk("rst_rready", {31'd0, axi.RREADY}, 32'd0);
        chk("rst_bready", {31'd0, axi.BREADY}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_araddr", axi.ARADDR, 32'd0);
        chk("rst_wlast", {31'd0, axi.WLAST}, 32'd1);
        chk("rst_arsize", {29'd0, axi.ARSIZE}, 32'd2);
        chk("rst_awburst", {30'd0, axi.AWBURST}, 32'd1);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;

        // Zero-wait load
        slv_rdata = 32'hDEAD_BEEF;
        cpu_op(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, cyc);
        chk("load_latency", 32'(cyc), 32'd2);

        // Store with AW and W accepted together
        cpu_op(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 32'h0, cyc);
        chk("store_latency", 32'(cyc), 32'd2);

        // Store with WREADY three cycles after the AW handshake
        w_rdy = 1'b0;
        fork
            begin
                repeat (3) @(negedge ACLK);
                chk("aw_dropped", {31'd0, axi.AWVALID}, 32'd0);
                chk("w_pending", {31'd0, axi.WVALID}, 32'd1);
                chk("bready_low", {31'd0, axi.BREADY}, 32'd0);
                chk("w_wait_stall", {31'd0, stall_o}, 32'd1);
                repeat (2) @(posedge ACLK);
                #1 w_rdy = 1'b1;
            end
        join_none
        cpu_op(1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'b1111, 32'h0, cyc);
        chk("store_wdelay_latency", 32'(cyc), 32'd5);

        // Back-to-back load then store
        slv_rdata = 32'h0BAD_F00D;
        cpu_op(1'b0, 32'h0000_0030, 32'h0, 4'h0, 32'h0BAD_F00D, cyc);
        chk("b2b_load_latency", 32'(cyc), 32'd2);
        cpu_op(1'b1, 32'h0000_0034, 32'hA5A5_5A5A, 4'b1100, 32'h0, cyc);
        chk("b2b_store_latency", 32'(cyc), 32'd2);

        // Reset while waiting for read data
        r_en = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0040;
        exp_ar_q.push_back(32'h0000_0040);
        n = 0;
        @(negedge ACLK);
        while (!axi.RREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("reached_rd_data", {31'd0, axi.RREADY}, 32'd1);
        #2;
        ARESETn   = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rstmid_rready", {31'd0, axi.RREADY}, 32'd0);
        chk("rstmid_arvalid", {31'd0, axi.ARVALID}, 32'd0);
        chk("rstmid_awvalid", {31'd0, axi.AWVALID}, 32'd0);
        chk("rstmid_wvalid", {31'd0, axi.WVALID}, 32'd0);
        chk("rstmid_bready", {31'd0, axi.BREADY}, 32'd0);
        chk("rstmid_idle", {31'd0, stall_o}, 32'd0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        r_en    = 1'b1;
        slv_rdata = 32'h5555_AAAA;
        cpu_op(1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h5555_AAAA, cyc);
        chk("post_reset_load_latency", 32'(cyc), 32'd2);

        // Error response
        slv_bresp = 2'b10;
        cpu_op(1'b1, 32'h0000_0050, 32'h0F0F_0F0F, 4'b0001, 32'h0, cyc);
        chk("err_store_latency", 32'(cyc), 32'd2);
        slv_bresp = 2'b00;
`ifdef CPU_AXI_MASTER_ERR_EN
        chk("err_set", {31'd0, err_o}, 32'd1);
`else
        chk("err_tied", {31'd0, err_o}, 32'd0);
`endif
        slv_rdata = 32'h7777_0001;
        cpu_op(1'b0, 32'h0000_0054, 32'h0, 4'h0, 32'h7777_0001, cyc);
`ifdef CPU_AXI_MASTER_ERR_EN
        chk("err_sticky", {31'd0, err_o}, 32'd1);
`else
        chk("err_tied_after_load", {31'd0, err_o}, 32'd0);
`endif

        repeat (2) @(negedge ACLK);
        chk("queues_drained",
            32'(exp_ar_q.size() + exp_aw_q.size() + exp_wd_q.size() + exp_rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
